// File: rtl/cpu24_pkg.sv
// Shared types and constants for the 24-bit CPU register file write path.
package cpu24_pkg;

  localparam int DATA_W     = 24;
  localparam int REG_ADDR_W = 4;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 4'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wbq_entry_t;

endpackage

// File: rtl/regq_match.sv
// Newest-match lookup over the pending writeback entries, scanned in age order.
module regq_match
  import cpu24_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  wbq_entry_t              entries [DEPTH],
  input  logic [DEPTH-1:0]        valid,
  input  logic [PTR_W-1:0]        wrPtr,
  input  logic [REG_ADDR_W-1:0]   lookup,
  output logic                    hit,
  output logic [DATA_W-1:0]       data
);

  logic [PTR_W-1:0] idx_s;

  // Walk oldest to newest so the entry nearest wrPtr overwrites older matches.
  always_comb begin
    hit   = 1'b0;
    data  = '0;
    idx_s = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx_s = wrPtr - PTR_W'(k);
      if ((lookup != ZERO_REG) && valid[idx_s] && (entries[idx_s].rd == lookup)) begin
        hit  = 1'b1;
        data = entries[idx_s].data;
      end else begin
        hit  = hit;
        data = data;
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// Writeback FIFO draining one result per cycle onto the register file write port.
// Define REGQ_FORWARD_EN to forward pending values to the RS/RT readers.
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wr_hold,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  output logic              fwd_rs_hit,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rt_data,
  output logic [ADDR_W:0]   count,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  cpu24_pkg::wbq_entry_t entries_r [DEPTH];
  logic [PTR_W-1:0] wrPtr_r;
  logic [PTR_W-1:0] rdPtr_r;
  logic [ADDR_W:0]  count_r;
  logic             push_s;
  logic             pop_s;

  assign count    = count_r;
  assign empty    = (count_r == '0);
  assign in_ready = (count_r != DEPTH_C);
  assign RegWrite = !empty && !wr_hold;
  assign pop_s    = RegWrite;
  // Register 0 writes are handshaken normally but never enter the queue.
  assign push_s   = in_valid && in_ready && (in_rd != cpu24_pkg::ZERO_REG);

  // Head entry onto the write port, zero while nothing is pending.
  always_comb begin
    if (!empty) begin
      RD        = entries_r[rdPtr_r].rd;
      WriteData = entries_r[rdPtr_r].data;
    end else begin
      RD        = '0;
      WriteData = '0;
    end
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        entries_r[wrPtr_r] <= '{rd: in_rd, data: in_data};
        wrPtr_r            <= wrPtr_r + PTR_ONE;
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef REGQ_FORWARD_EN
  logic [DEPTH-1:0] validMask_s;

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    validMask_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      validMask_s[i] = ((ADDR_W+1)'(PTR_W'(i) - rdPtr_r) < count_r);
    end
  end

  regq_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_matchRs (
    .entries (entries_r),
    .valid   (validMask_s),
    .wrPtr   (wrPtr_r),
    .lookup  (RS),
    .hit     (fwd_rs_hit),
    .data    (fwd_rs_data)
  );

  regq_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_matchRt (
    .entries (entries_r),
    .valid   (validMask_s),
    .wrPtr   (wrPtr_r),
    .lookup  (RT),
    .hit     (fwd_rt_hit),
    .data    (fwd_rt_data)
  );
`else
  logic unusedLookup_s;
  assign unusedLookup_s = ^{RS, RT};
  assign fwd_rs_hit  = 1'b0;
  assign fwd_rs_data = '0;
  assign fwd_rt_hit  = 1'b0;
  assign fwd_rt_data = '0;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench for regfile_write_queue: directed scenarios plus a randomized run against a queue model.
module tb_regfile_write_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 4;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic              wr_hold;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic [ADDR_W-1:0] RS;
  logic [ADDR_W-1:0] RT;
  logic              fwd_rs_hit;
  logic [DATA_W-1:0] fwd_rs_data;
  logic              fwd_rt_hit;
  logic [DATA_W-1:0] fwd_rt_data;
  logic [ADDR_W:0]   count;
  logic              empty;

  int vectors = 0;
  int errors  = 0;

  regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .wr_hold(wr_hold), .RD(RD),
    .WriteData(WriteData), .RegWrite(RegWrite), .RS(RS), .RT(RT),
    .fwd_rs_hit(fwd_rs_hit), .fwd_rs_data(fwd_rs_data),
    .fwd_rt_hit(fwd_rt_hit), .fwd_rt_data(fwd_rt_data),
    .count(count), .empty(empty)
  );

  always #5 Clock = ~Clock;

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
    wr_hold = 1'b0; RS = '0; RT = '0;
    next_cycle(); next_cycle();
    vectors++;
    if ({RegWrite, RD, WriteData, in_ready, empty, count, fwd_rs_hit, fwd_rs_data, fwd_rt_hit, fwd_rt_data}
        !== {1'b0, 4'd0, 24'd0, 1'b1, 1'b1, 5'd0, 1'b0, 24'd0, 1'b0, 24'd0}) begin
      errors++;
      $display("FAIL reset_state got RegWrite=%0b RD=%0d WD=%h rdy=%0b empty=%0b count=%0d exp 0/0/0/1/1/0",
               RegWrite, RD, WriteData, in_ready, empty, count);
    end
    Reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_write();
    in_valid = 1'b1; in_rd = 4'd8; in_data = 24'd4;
    next_cycle();
    in_valid = 1'b0;
    #1;
    vectors++;
    if ({RegWrite, RD, WriteData, count} !== {1'b1, 4'd8, 24'd4, 5'd1}) begin
      errors++;
      $display("FAIL single_port got RegWrite=%0b RD=%0d WD=%h count=%0d exp 1/8/4/1", RegWrite, RD, WriteData, count);
    end
    next_cycle();
    vectors++;
    if ({empty, RegWrite} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_drained got empty=%0b RegWrite=%0b exp 1/0", empty, RegWrite);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] peak;
    in_valid = 1'b1; in_rd = 4'd8; in_data = 24'd4;
    next_cycle();
    in_rd = 4'd9; in_data = 24'd2;
    #1;
    peak = count;
    vectors++;
    if ({RegWrite, RD, WriteData} !== {1'b1, 4'd8, 24'd4}) begin
      errors++;
      $display("FAIL b2b_first got RegWrite=%0b RD=%0d WD=%h exp 1/8/4", RegWrite, RD, WriteData);
    end
    next_cycle();
    in_valid = 1'b0;
    #1;
    if (count > peak) peak = count;
    vectors++;
    if ({RegWrite, RD, WriteData} !== {1'b1, 4'd9, 24'd2}) begin
      errors++;
      $display("FAIL b2b_second got RegWrite=%0b RD=%0d WD=%h exp 1/9/2", RegWrite, RD, WriteData);
    end
    next_cycle();
    vectors++;
    if ({peak, empty} !== {5'd1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_peak got peak=%0d empty=%0b exp 1/1", peak, empty);
    end
  endtask

  task automatic test_full_hold();
    logic [27:0] seen[$];
    int cycles;
    wr_hold = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_rd = ADDR_W'(i); in_data = DATA_W'(32'h10 + i - 1);
      next_cycle();
    end
    in_rd = 4'd5; in_data = 24'h14;
    #1;
    vectors++;
    if ({in_ready, count, RegWrite} !== {1'b0, 5'd4, 1'b0}) begin
      errors++;
      $display("FAIL full_state got rdy=%0b count=%0d RegWrite=%0b exp 0/4/0", in_ready, count, RegWrite);
    end
    next_cycle();
    vectors++;
    if ({count, RD, WriteData} !== {5'd4, 4'd1, 24'h10}) begin
      errors++;
      $display("FAIL hold_stable got count=%0d RD=%0d WD=%h exp 4/1/10", count, RD, WriteData);
    end
    wr_hold = 1'b0;
    cycles = 0;
    while (cycles < 20 && (in_valid || !empty)) begin
      #1;
      if (RegWrite) seen.push_back({RD, WriteData});
      if (in_valid && in_ready) begin
        next_cycle();
        in_valid = 1'b0;
      end else begin
        next_cycle();
      end
      cycles++;
    end
    vectors++;
    if (seen.size() != 5 || cycles >= 20) begin
      errors++;
      $display("FAIL full_order_count got writes=%0d cycles=%0d exp 5 writes", seen.size(), cycles);
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (seen[i] !== {ADDR_W'(i + 1), DATA_W'(32'h10 + i)}) begin
          errors++;
          $display("FAIL full_order_%0d got %h exp rd=%0d data=%h", i, seen[i], i + 1, 32'h10 + i);
        end
      end
    end
  endtask

  task automatic test_reg0_drop();
    int writes = 0;
    in_valid = 1'b1; in_rd = 4'd0; in_data = 24'hFFFFFF;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reg0_ready got %0b exp 1", in_ready);
    end
    next_cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (RegWrite || count != 0) writes++;
      next_cycle();
    end
    vectors++;
    if (writes !== 0) begin
      errors++;
      $display("FAIL reg0_dropped got %0d cycles with RegWrite/count set exp 0", writes);
    end
  endtask

  task automatic test_forwarding();
    logic expHit;
    logic [23:0] expData;
    wr_hold = 1'b1; in_valid = 1'b1;
    in_rd = 4'd3; in_data = 24'hA;
    next_cycle();
    in_data = 24'hB;
    next_cycle();
    in_valid = 1'b0; RS = 4'd3; RT = 4'd7;
    #1;
`ifdef REGQ_FORWARD_EN
    expHit = 1'b1; expData = 24'hB;
`else
    expHit = 1'b0; expData = 24'h0;
`endif
    vectors++;
    if ({fwd_rs_hit, fwd_rs_data, fwd_rt_hit, fwd_rt_data} !== {expHit, expData, 1'b0, 24'd0}) begin
      errors++;
      $display("FAIL fwd_lookup got rs=%0b/%h rt=%0b/%h exp rs=%0b/%h rt=0/0",
               fwd_rs_hit, fwd_rs_data, fwd_rt_hit, fwd_rt_data, expHit, expData);
    end
    wr_hold = 1'b0; RS = '0; RT = '0;
    for (int i = 0; i < 6 && !empty; i++) next_cycle();
    vectors++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL fwd_drain got empty=%0b exp 1", empty);
    end
  endtask

  task automatic test_reset_mid_drain();
    int stale = 0;
    wr_hold = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_rd = ADDR_W'(10 + i); in_data = DATA_W'(32'h500 + i);
      next_cycle();
    end
    in_valid = 1'b0; wr_hold = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    vectors++;
    if ({RegWrite, RD, WriteData, count, empty, in_ready} !== {1'b0, 4'd0, 24'd0, 5'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_drain got RegWrite=%0b RD=%0d WD=%h count=%0d exp 0/0/0/0",
               RegWrite, RD, WriteData, count);
    end
    next_cycle();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (RegWrite || count != 0) stale++;
      next_cycle();
    end
    vectors++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL reset_no_stale got %0d stale cycles exp 0", stale);
    end
  endtask

  task automatic test_random();
    logic [3:0]  qRd[$];
    logic [23:0] qData[$];
    logic        expRdy, expWr, rsHit, rtHit;
    logic [3:0]  expRd;
    logic [23:0] expWd, rsData, rtData;
    logic [87:0] expV, gotV;
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_rd    = ADDR_W'($urandom_range(0, 5));
      in_data  = DATA_W'($urandom);
      wr_hold  = ($urandom_range(0, 3) == 0);
      RS       = ADDR_W'($urandom_range(0, 5));
      RT       = ADDR_W'($urandom_range(0, 5));
      #1;
      expRdy = (qRd.size() != DEPTH);
      expWr  = (qRd.size() != 0) && !wr_hold;
      expRd  = (qRd.size() != 0) ? qRd[0] : 4'd0;
      expWd  = (qRd.size() != 0) ? qData[0] : 24'd0;
      rsHit = 1'b0; rsData = '0; rtHit = 1'b0; rtData = '0;
`ifdef REGQ_FORWARD_EN
      for (int i = qRd.size() - 1; i >= 0; i--) begin
        if (!rsHit && RS != 0 && qRd[i] == RS) begin rsHit = 1'b1; rsData = qData[i]; end
        if (!rtHit && RT != 0 && qRd[i] == RT) begin rtHit = 1'b1; rtData = qData[i]; end
      end
`endif
      expV = {expRdy, expWr, expRd, expWd, 5'(qRd.size()), (qRd.size() == 0), rsHit, rsData, rtHit, rtData};
      gotV = {in_ready, RegWrite, RD, WriteData, count, empty, fwd_rs_hit, fwd_rs_data, fwd_rt_hit, fwd_rt_data};
      vectors++;
      if (gotV !== expV) begin
        errors++;
        $display("FAIL random_cycle_%0d got %h exp %h", n, gotV, expV);
      end
      if (expWr) begin
        void'(qRd.pop_front());
        void'(qData.pop_front());
      end
      if (in_valid && expRdy && in_rd != 0) begin
        qRd.push_back(in_rd);
        qData.push_back(in_data);
      end
      next_cycle();
    end
    in_valid = 1'b0; wr_hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_full_hold();
    test_reg0_drop();
    test_forwarding();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Write-side initiator for the 24-bit CPU register file: buffers writeback results (destination register plus 24-bit data) from the ALU/memory stages in a small FIFO.
- Drains one entry per cycle onto the register file write port (RD, WriteData, RegWrite).
- Optionally forwards pending, not-yet-written values to RS/RT readers so decode sees the newest value.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- DATA_W, 24, register data width.
- ADDR_W, 4, register index width (16 registers).

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a writeback result.
- in_ready  output  1  queue can accept; a push occurs when in_valid && in_ready at a rising edge.
- in_rd  input  ADDR_W  destination register of the result.
- in_data  input  DATA_W  result value.
- wr_hold  input  1  register file write port unavailable this cycle; suppresses the drain.
- RD  output  ADDR_W  write-port register index (head entry).
- WriteData  output  DATA_W  write-port data (head entry).
- RegWrite  output  1  write strobe; the register file samples on the same rising edge.
- RS  input  ADDR_W  forwarding lookup index A.
- RT  input  ADDR_W  forwarding lookup index B.
- fwd_rs_hit  output  1  a pending entry targets RS.
- fwd_rs_data  output  DATA_W  newest pending value for RS.
- fwd_rt_hit  output  1  a pending entry targets RT.
- fwd_rt_data  output  DATA_W  newest pending value for RT.
- count  output  ADDR_W+1  number of occupied entries.
- empty  output  1  count == 0.

Behaviour:
- Reset (asynchronous, active-high): wr_ptr = rd_ptr = 0 and count = 0; every pending entry is discarded, including on reset mid-drain. During and after reset: RegWrite = 0, RD = 0, WriteData = 0, in_ready = 1, empty = 1, and all fwd outputs are 0.
- Push: on in_valid && in_ready, store {in_rd, in_data} at wr_ptr, then wr_ptr++ (wraps modulo DEPTH).
- Writes to register 0: in_rd == 0 is accepted (in_ready behaves as normal) but not stored. Register 0 is hard-wired zero.
- in_ready = (count != DEPTH). There is no pass-through when full, even if a pop happens in the same cycle.
- Write port:
  - RegWrite = !empty && !wr_hold.
  - RD and WriteData show the head entry when !empty, otherwise 0.
  - All three are driven purely from registered state; there is no combinational path from in_* to the write port.
- Pop: on a rising edge with RegWrite = 1, rd_ptr++ (wraps).
- Latency: a result pushed at edge N into an empty queue drives RegWrite in the cycle after N and is written at edge N+1.
- Simultaneous push and pop: count is unchanged and both pointers advance. Legal at any count < DEPTH.
- Ordering: strict FIFO. Two entries to the same register are written in push order, so the last value wins.
- wr_hold held for several cycles: the head is held stable and RegWrite stays 0. Pushes continue until full.
- count saturates only by means of in_ready. Overflow and underflow are impossible by construction.

Optional Feature:
- Macro: REGQ_FORWARD_EN.
- Defined:
  - fwd_rs_hit is set when any valid entry has rd == RS, and RS != 0; fwd_rt_hit likewise for RT.
  - fwd_*_data is the data of the newest matching entry (closest to wr_ptr).
  - The lookup is combinational on RS/RT and the registered entries. It includes the head being popped this cycle and excludes the same-cycle push.
- Undefined: fwd_* outputs are tied to 0 and no match logic is synthesised.

Decomposition:
- Package cpu24_pkg holds:
  - DATA_W = 24, REG_ADDR_W = 4, ZERO_REG = 4'd0.
  - typedef wbq_entry_t {logic [REG_ADDR_W-1:0] rd; logic [DATA_W-1:0] data;}.
- Sub-module regq_match, instantiated twice (RS and RT) under REGQ_FORWARD_EN:
  - Inputs: the entry array, valid mask, wr_ptr and the lookup index.
  - Outputs: hit and data.
  - Selects the newest match by age order from wr_ptr-1 backwards.

Test Plan:
- Single write:
  - Stimulus: reset, then push rd=8 data=4.
  - Required: the next cycle shows RegWrite=1, RD=8, WriteData=4; after one edge, empty=1 and RegWrite=0.
- Back-to-back writes:
  - Stimulus: push rd=8/4 then rd=9/2 on consecutive edges.
  - Required: the write port shows 8/4 then 9/2 on consecutive cycles, and count peaks at 1.
- Full and hold:
  - Stimulus: wr_hold=1; push 5 entries rd=1..5 with data=0x10..0x14.
  - Required: in_ready drops after 4 pushes and count=4. Release wr_hold: writes occur in order 1..4; with in_valid held, rd=5 is accepted once in_ready returns.
- Register 0 drop:
  - Stimulus: push rd=0 data=0xFFFFFF.
  - Required: in_ready=1, count stays 0, RegWrite never asserts.
- Forwarding (REGQ_FORWARD_EN):
  - Stimulus: wr_hold=1; push rd=3/0xA, then rd=3/0xB; set RS=3, RT=7.
  - Required: fwd_rs_hit=1 with data=0xB, fwd_rt_hit=0. Without the macro, all fwd_* outputs are 0.
- Reset mid-drain:
  - Stimulus: with 3 entries pending, assert Reset between edges.
  - Required: RegWrite, RD and WriteData go to 0 immediately; after release, count=0 and no stale write occurs.
